// File: rtl/rf_pkg.sv
// Shared register-file widths and the write-buffer entry record.
// Pure declarations; no logic, no latency, no flow control.
// Imported by every file of the write-back buffer slice.
package rf_pkg;

    localparam int REG_W            = 32;
    localparam int ADDR_W           = 5;
    localparam int NREGS            = 32;
    localparam int WB_DEPTH_DEFAULT = 4;

    typedef struct packed {
        logic [ADDR_W-1:0] dr;
        logic [REG_W-1:0]  data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fwd_match.sv
// One forwarding lookup port over the pending writes: newest match wins.
// Latency: purely combinational.
// Backpressure: none; it only observes buffer state.
module wb_fwd_match
    import rf_pkg::*;
#(
    parameter int DEPTH = WB_DEPTH_DEFAULT
) (
    input  logic [ADDR_W-1:0]      addr,
    input  logic [DEPTH-1:0]       ent_vld,
    input  wb_entry_t [DEPTH-1:0]  ent,
    input  logic                   out_vld,
    input  wb_entry_t              out_ent,
    output logic                   hit,
    output logic [REG_W-1:0]       data
);

    // Entries arrive oldest-first (index 0); scanning upward lets younger
    // matches overwrite older ones, with the output register as the oldest.
    always_comb begin
        hit  = 1'b0;
        data = '0;
        if (out_vld && (out_ent.dr == addr)) begin
            hit  = 1'b1;
            data = out_ent.data;
        end
        for (int k = 0; k < DEPTH; k++) begin
            if (ent_vld[k] && (ent[k].dr == addr)) begin
                hit  = 1'b1;
                data = ent[k].data;
            end
        end
    end

endmodule

// File: rtl/wb_buffer.sv
// Write-back buffer: queues register writes in order and drains one per cycle to the bank.
// Latency: accepted at edge N, write strobe valid after edge N+1.
// Backpressure: in_ready drops when full or in reset; hold stalls draining indefinitely.
module wb_buffer
    import rf_pkg::*;
#(
    parameter int DEPTH = WB_DEPTH_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [ADDR_W-1:0] in_dr,
    input  logic [REG_W-1:0]  in_data,
    output logic              in_ready,
    input  logic              hold,
    output logic              write,
    output logic [ADDR_W-1:0] dr,
    output logic [REG_W-1:0]  wrData,
    input  logic [ADDR_W-1:0] sr1,
    input  logic [ADDR_W-1:0] sr2,
    output logic              fwd1_hit,
    output logic              fwd2_hit,
    output logic [REG_W-1:0]  fwd1_data,
    output logic [REG_W-1:0]  fwd2_data
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    wb_entry_t              mem_q [DEPTH];
    wb_entry_t              mem_d [DEPTH];
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic                   write_q, write_d;
    wb_entry_t              out_q, out_d;

    logic                   push;
    logic                   pop;
    wb_entry_t [DEPTH-1:0]  ord_ent;
    logic [DEPTH-1:0]       ord_vld;

    // Ready depends only on registered count: a same-edge pop never frees a slot.
    assign in_ready = !reset && (count_q < CNT_W'(DEPTH));
    assign push     = in_valid && in_ready;
    assign pop      = (count_q != '0) && !hold;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
        write_d  = 1'b0;
        out_d    = out_q;
        if (push) begin
            mem_d[wr_ptr_q] = '{dr: in_dr, data: in_data};
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            write_d  = 1'b1;
            out_d    = mem_q[rd_ptr_q];
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            write_q  <= 1'b0;
            out_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            write_q  <= write_d;
            out_q    <= out_d;
        end
    end

    // Storage needs no reset; validity comes from count and pointers.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    // Oldest-first view of the live entries for the forwarding ports.
    always_comb begin
        ord_ent = '0;
        ord_vld = '0;
        for (int k = 0; k < DEPTH; k++) begin
            ord_ent[k] = mem_q[rd_ptr_q + PTR_W'(k)];
            ord_vld[k] = (CNT_W'(k) < count_q);
        end
    end

    wb_fwd_match #(.DEPTH(DEPTH)) u_fwd1 (
        .addr    (sr1),
        .ent_vld (ord_vld),
        .ent     (ord_ent),
        .out_vld (write_q),
        .out_ent (out_q),
        .hit     (fwd1_hit),
        .data    (fwd1_data)
    );

    wb_fwd_match #(.DEPTH(DEPTH)) u_fwd2 (
        .addr    (sr2),
        .ent_vld (ord_vld),
        .ent     (ord_ent),
        .out_vld (write_q),
        .out_ent (out_q),
        .hit     (fwd2_hit),
        .data    (fwd2_data)
    );

    assign write  = write_q;
    assign dr     = out_q.dr;
    assign wrData = out_q.data;

endmodule

// File: tb/tb_wb_buffer.sv
// Directed bench for wb_buffer (DEPTH=4) with a modelled register bank.
// Latency: inputs driven on the falling edge, outputs sampled 1 ns later.
// Backpressure: exercised through hold and the full condition.
module tb_wb_buffer;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [4:0]  in_dr;
    logic [31:0] in_data;
    logic        in_ready;
    logic        hold;
    logic        write;
    logic [4:0]  dr;
    logic [31:0] wrData;
    logic [4:0]  sr1, sr2;
    logic        fwd1_hit, fwd2_hit;
    logic [31:0] fwd1_data, fwd2_data;

    int n_chk  = 0;
    int n_fail = 0;

    logic [31:0] bank [32];
    int          wr_cnt = 0;

    always #5 clk = ~clk;

    wb_buffer #(.DEPTH(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_dr     (in_dr),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .hold      (hold),
        .write     (write),
        .dr        (dr),
        .wrData    (wrData),
        .sr1       (sr1),
        .sr2       (sr2),
        .fwd1_hit  (fwd1_hit),
        .fwd2_hit  (fwd2_hit),
        .fwd1_data (fwd1_data),
        .fwd2_data (fwd2_data)
    );

    initial begin
        for (int i = 0; i < 32; i++) bank[i] = '0;
    end

    // Bank captures the registered strobe one edge after it appears.
    always @(posedge clk) begin
        if (write) begin
            bank[dr] <= wrData;
            wr_cnt   <= wr_cnt + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct packed {
        logic        iv;
        logic [4:0]  idr;
        logic [31:0] idat;
        logic        hld;
        logic [4:0]  s1;
        logic [4:0]  s2;
        logic        rdy;
        logic        wr;
        logic [4:0]  odr;
        logic [31:0] owd;
        logic        h1;
        logic [31:0] d1;
        logic        h2;
        logic [31:0] d2;
    } vec_t;

    localparam int NV = 18;
    vec_t vecs [NV];
    int   base;

    initial begin
        // Each row: inputs for this cycle | outputs expected before the next edge.
        vecs[0]  = '{1'b1, 5'd3, 32'd103, 1'b0, 5'd3, 5'd0, 1'b1, 1'b0, 5'd0, 32'd0,   1'b0, 32'd0,   1'b0, 32'd0};
        vecs[1]  = '{1'b0, 5'd0, 32'd0,   1'b0, 5'd3, 5'd0, 1'b1, 1'b0, 5'd0, 32'd0,   1'b1, 32'd103, 1'b0, 32'd0};
        vecs[2]  = '{1'b0, 5'd0, 32'd0,   1'b0, 5'd3, 5'd0, 1'b1, 1'b1, 5'd3, 32'd103, 1'b1, 32'd103, 1'b0, 32'd0};
        vecs[3]  = '{1'b1, 5'd5, 32'd10,  1'b1, 5'd5, 5'd3, 1'b1, 1'b0, 5'd3, 32'd103, 1'b0, 32'd0,   1'b0, 32'd0};
        vecs[4]  = '{1'b1, 5'd5, 32'd20,  1'b1, 5'd5, 5'd3, 1'b1, 1'b0, 5'd3, 32'd103, 1'b1, 32'd10,  1'b0, 32'd0};
        vecs[5]  = '{1'b1, 5'd5, 32'd30,  1'b1, 5'd5, 5'd3, 1'b1, 1'b0, 5'd3, 32'd103, 1'b1, 32'd20,  1'b0, 32'd0};
        vecs[6]  = '{1'b1, 5'd5, 32'd40,  1'b1, 5'd5, 5'd3, 1'b1, 1'b0, 5'd3, 32'd103, 1'b1, 32'd30,  1'b0, 32'd0};
        vecs[7]  = '{1'b1, 5'd9, 32'd99,  1'b1, 5'd5, 5'd9, 1'b0, 1'b0, 5'd3, 32'd103, 1'b1, 32'd40,  1'b0, 32'd0};
        vecs[8]  = '{1'b1, 5'd9, 32'd99,  1'b0, 5'd5, 5'd9, 1'b0, 1'b0, 5'd3, 32'd103, 1'b1, 32'd40,  1'b0, 32'd0};
        vecs[9]  = '{1'b1, 5'd9, 32'd99,  1'b0, 5'd5, 5'd9, 1'b1, 1'b1, 5'd5, 32'd10,  1'b1, 32'd40,  1'b0, 32'd0};
        vecs[10] = '{1'b0, 5'd0, 32'd0,   1'b0, 5'd5, 5'd9, 1'b1, 1'b1, 5'd5, 32'd20,  1'b1, 32'd40,  1'b1, 32'd99};
        vecs[11] = '{1'b0, 5'd0, 32'd0,   1'b0, 5'd5, 5'd9, 1'b1, 1'b1, 5'd5, 32'd30,  1'b1, 32'd40,  1'b1, 32'd99};
        vecs[12] = '{1'b0, 5'd0, 32'd0,   1'b0, 5'd5, 5'd9, 1'b1, 1'b1, 5'd5, 32'd40,  1'b1, 32'd40,  1'b1, 32'd99};
        vecs[13] = '{1'b0, 5'd0, 32'd0,   1'b0, 5'd5, 5'd9, 1'b1, 1'b1, 5'd9, 32'd99,  1'b0, 32'd0,   1'b1, 32'd99};
        vecs[14] = '{1'b1, 5'd8, 32'd55,  1'b0, 5'd7, 5'd8, 1'b1, 1'b0, 5'd9, 32'd99,  1'b0, 32'd0,   1'b0, 32'd0};
        vecs[15] = '{1'b0, 5'd0, 32'd0,   1'b0, 5'd7, 5'd8, 1'b1, 1'b0, 5'd9, 32'd99,  1'b0, 32'd0,   1'b1, 32'd55};
        vecs[16] = '{1'b0, 5'd0, 32'd0,   1'b0, 5'd7, 5'd8, 1'b1, 1'b1, 5'd8, 32'd55,  1'b0, 32'd0,   1'b1, 32'd55};
        vecs[17] = '{1'b0, 5'd0, 32'd0,   1'b0, 5'd7, 5'd8, 1'b1, 1'b0, 5'd8, 32'd55,  1'b0, 32'd0,   1'b0, 32'd0};

        reset    = 1'b1;
        in_valid = 1'b0;
        in_dr    = '0;
        in_data  = '0;
        hold     = 1'b0;
        sr1      = '0;
        sr2      = '0;

        repeat (2) @(negedge clk);
        #1;
        chk("rst_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_write", {31'd0, write}, 32'd0);
        chk("rst_dr", {27'd0, dr}, 32'd0);
        chk("rst_wrdata", wrData, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("post_rst_ready", {31'd0, in_ready}, 32'd1);

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            in_valid = vecs[i].iv;
            in_dr    = vecs[i].idr;
            in_data  = vecs[i].idat;
            hold     = vecs[i].hld;
            sr1      = vecs[i].s1;
            sr2      = vecs[i].s2;
            #1;
            chk($sformatf("v%0d_ready", i), {31'd0, in_ready}, {31'd0, vecs[i].rdy});
            chk($sformatf("v%0d_write", i), {31'd0, write}, {31'd0, vecs[i].wr});
            chk($sformatf("v%0d_dr", i), {27'd0, dr}, {27'd0, vecs[i].odr});
            chk($sformatf("v%0d_wrdata", i), wrData, vecs[i].owd);
            chk($sformatf("v%0d_fwd1_hit", i), {31'd0, fwd1_hit}, {31'd0, vecs[i].h1});
            chk($sformatf("v%0d_fwd1_data", i), fwd1_data, vecs[i].d1);
            chk($sformatf("v%0d_fwd2_hit", i), {31'd0, fwd2_hit}, {31'd0, vecs[i].h2});
            chk($sformatf("v%0d_fwd2_data", i), fwd2_data, vecs[i].d2);
        end
        chk("bank3", bank[3], 32'd103);
        chk("bank5", bank[5], 32'd40);
        chk("bank9", bank[9], 32'd99);
        chk("bank8", bank[8], 32'd55);

        // Back-to-back stream with hold low: every register gets k+100 in order.
        base = wr_cnt;
        for (int k = 0; k < 32; k++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_dr    = 5'(k);
            in_data  = 32'(k + 100);
            #1;
            chk($sformatf("stream_ready%0d", k), {31'd0, in_ready}, 32'd1);
        end
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("stream_pulses", 32'(wr_cnt - base), 32'd32);
        for (int k = 0; k < 32; k++) begin
            chk($sformatf("stream_bank%0d", k), bank[k], 32'(k + 100));
        end

        // Two entries pending under hold, then a one-cycle reset discards them.
        @(negedge clk);
        hold     = 1'b1;
        in_valid = 1'b1;
        in_dr    = 5'd20;
        in_data  = 32'hAAAA;
        @(negedge clk);
        in_dr    = 5'd21;
        in_data  = 32'hBBBB;
        @(negedge clk);
        in_dr    = 5'd22;
        in_data  = 32'hCCCC;
        sr1      = 5'd20;
        sr2      = 5'd21;
        reset    = 1'b1;
        #1;
        chk("pend_fwd1_hit", {31'd0, fwd1_hit}, 32'd1);
        chk("pend_fwd1_data", fwd1_data, 32'hAAAA);
        chk("pend_fwd2_hit", {31'd0, fwd2_hit}, 32'd1);
        chk("pend_fwd2_data", fwd2_data, 32'hBBBB);
        chk("inrst_ready", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        reset    = 1'b0;
        in_valid = 1'b0;
        hold     = 1'b0;
        sr2      = 5'd22;
        base     = wr_cnt;
        #1;
        chk("rst2_write", {31'd0, write}, 32'd0);
        chk("rst2_dr", {27'd0, dr}, 32'd0);
        chk("rst2_wrdata", wrData, 32'd0);
        chk("rst2_fwd1_hit", {31'd0, fwd1_hit}, 32'd0);
        chk("rst2_fwd1_data", fwd1_data, 32'd0);
        chk("rst2_fwd2_hit", {31'd0, fwd2_hit}, 32'd0);
        chk("rst2_fwd2_data", fwd2_data, 32'd0);
        repeat (5) @(negedge clk);
        #1;
        chk("rst2_no_pulses", 32'(wr_cnt - base), 32'd0);
        chk("rst2_bank20", bank[20], 32'd120);
        chk("rst2_bank21", bank[21], 32'd121);
        chk("rst2_bank22", bank[22], 32'd122);
        chk("rst2_ready", {31'd0, in_ready}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_buffer.md
WB_BUFFER -- requirements
Module: wb_buffer

Interface
REQ-001 Parameter DEPTH, default 4, number of pending-write entries; legal values 2, 4, 8.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  producer offers a register write this cycle.
REQ-005 in_dr  input  5  destination register of offered write.
REQ-006 in_data  input  32  data of offered write.
REQ-007 in_ready  output  1  buffer accepts offered write this cycle.
REQ-008 hold  input  1  register bank write port unavailable; stalls draining.
REQ-009 write  output  1  registered write strobe to register bank.
REQ-010 dr  output  5  registered destination register to register bank.
REQ-011 wrData  output  32  registered write data to register bank.
REQ-012 sr1, sr2  input  5 each  read addresses presented to register bank, used for forwarding lookup.
REQ-013 fwd1_hit, fwd2_hit  output  1 each  a pending write targets sr1 / sr2.
REQ-014 fwd1_data, fwd2_data  output  32 each  newest pending data for sr1 / sr2; 0 when no hit.

Function
REQ-015 Push: at a rising edge with in_valid=1 and in_ready=1, {in_dr, in_data} SHALL be appended at tail.
REQ-016 in_ready SHALL be combinational: 1 when count < DEPTH and reset=0, else 0.
REQ-017 in_valid with in_ready=0 SHALL be ignored; producer holds it until accepted.
REQ-018 Drain: at a rising edge with count>0 and hold=0, head SHALL be popped into {dr, wrData} and write set to 1.
REQ-019 At a rising edge with no drain, write SHALL be 0; dr and wrData SHALL keep previous values.
REQ-020 Minimum latency: write accepted at edge N appears with write=1 after edge N+1; bank captures it at edge N+2.
REQ-021 Writes SHALL reach the bank in acceptance order; no coalescing, no reordering, register 0 treated like any other.
REQ-022 Simultaneous push and drain SHALL both occur; count unchanged.
REQ-023 Push when count=DEPTH-1 with no drain SHALL make count=DEPTH and deassert in_ready combinationally the same cycle.
REQ-024 Push while full is impossible (in_ready=0) even if a drain occurs that edge; no combinational ready-on-pop path.
REQ-025 Read and write pointers SHALL wrap modulo DEPTH; count SHALL range 0..DEPTH.
REQ-026 Forwarding SHALL be purely combinational over valid FIFO entries plus the output register when write=1.
REQ-027 Priority, newest first: youngest matching FIFO entry, then older entries, then output register.
REQ-028 A write on in_dr/in_data in the current cycle SHALL NOT be forwarded until accepted.
REQ-029 hold may be asserted indefinitely; contents and order SHALL be preserved and forwarding SHALL remain valid.

Reset
REQ-030 While reset=1 at a rising edge: count=0, pointers=0, write=0, dr=0, wrData=0.
REQ-031 Reset mid-operation SHALL discard all pending entries; none SHALL reach the bank afterwards.
REQ-032 After reset, fwd*_hit=0 and fwd*_data=0 until a new push.
REQ-033 in_ready SHALL be 0 while reset=1; inputs ignored during reset.

Structure
REQ-034 Shared package rf_pkg SHALL hold REG_W=32, ADDR_W=5, NREGS=32, WB_DEPTH_DEFAULT=4.
REQ-035 One sub-module wb_fwd_match (one lookup port: address in, hit and data out) SHALL be instantiated twice.
REQ-036 FIFO storage SHALL be flop-based arrays; no memory macros.

Verification
REQ-037 Reset, push dr=3 data=103 -> write=1 dr=3 wrData=103 exactly one cycle after acceptance; bank reg[3]=103.
REQ-038 hold=1, push dr=5 data 10,20,30,40 (DEPTH=4) -> in_ready=0 after 4th; sr1=5 gives fwd1_hit=1 fwd1_data=40.
REQ-039 Release hold from full -> four consecutive write pulses dr=5 data 10,20,30,40; in_ready=1 after first drain.
REQ-040 Continuous push every cycle with hold=0, dr=k data=k+100 for k=0..31 -> bank reads reg[k]=k+100 for all k.
REQ-041 Two pending entries, reset asserted one cycle -> no write pulse afterwards; fwd hits 0; bank unchanged.
REQ-042 sr1=7 sr2=8 with only output register holding dr=8 data=55 -> fwd1_hit=0 fwd2_hit=1 fwd2_data=55.
